// File: rtl/byte_serial_adder_ctrl.sv
// Byte-serial add/subtract controller: one 8-bit slice adder reused over
// NBYTES cycles, LSB first, with the carry held in a register between bytes.
module byte_serial_adder_ctrl #(
  parameter int NBYTES = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_op,
  input  logic [8*NBYTES-1:0]   i_a,
  input  logic [8*NBYTES-1:0]   i_b,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [8*NBYTES-1:0]   o_result,
  output logic                  o_cout
);
  localparam int W  = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         r_state, w_next;
  logic [W-1:0]   r_a, r_b, r_result;
  logic           r_op, r_carry, r_cout;
  logic [CW-1:0]  r_idx;
  logic           w_accept, w_last;
  logic [7:0]     w_b_byte;
  logic [8:0]     w_sum;

  // Operands shift down one byte per RUN cycle so the slice always sees bit 0.
  assign w_b_byte = r_b[7:0] ^ {8{r_op}};
  assign w_sum    = {1'b0, r_a[7:0]} + {1'b0, w_b_byte} + {8'd0, r_carry};
  assign w_last   = (r_idx == CW'(NBYTES - 1));
  assign w_accept = i_start & o_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    o_ready = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_start) w_next = S_RUN;
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        o_ready = 1'b1;
        o_done  = 1'b1;
        w_next  = i_start ? S_RUN : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 1'b0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_op    <= i_op;
      r_carry <= i_op;
      r_idx   <= '0;
    end else if (o_busy) begin
      r_a     <= r_a >> 8;
      r_b     <= r_b >> 8;
      r_carry <= w_sum[8];
      for (int k = 0; k < NBYTES; k++)
        if (r_idx == CW'(k)) r_result[8*k +: 8] <= w_sum[7:0];
      if (w_last) r_cout <= w_sum[8];
      else        r_idx  <= r_idx + 1'b1;
    end
  end

  assign o_result = r_result;
  assign o_cout   = r_cout;
endmodule

// File: tb/tb_byte_serial_adder_ctrl.sv
// Bench for byte_serial_adder_ctrl: directed table + corner sequences on
// NBYTES=3, random sweeps on NBYTES=2 and NBYTES=4 against an arithmetic model.
module tb_byte_serial_adder_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic        s2 = 0, s3 = 0, s4 = 0, op2 = 0, op3 = 0, op4 = 0;
  logic [15:0] a2 = 0, b2 = 0, res2;
  logic [23:0] a3 = 0, b3 = 0, res3;
  logic [31:0] a4 = 0, b4 = 0, res4;
  logic        rdy2, bsy2, dn2, co2, rdy3, bsy3, dn3, co3, rdy4, bsy4, dn4, co4;

  byte_serial_adder_ctrl #(.NBYTES(2)) u2 (.i_clk(clk), .i_rst(rst), .i_start(s2), .i_op(op2),
    .i_a(a2), .i_b(b2), .o_ready(rdy2), .o_busy(bsy2), .o_done(dn2), .o_result(res2), .o_cout(co2));
  byte_serial_adder_ctrl #(.NBYTES(3)) u3 (.i_clk(clk), .i_rst(rst), .i_start(s3), .i_op(op3),
    .i_a(a3), .i_b(b3), .o_ready(rdy3), .o_busy(bsy3), .o_done(dn3), .o_result(res3), .o_cout(co3));
  byte_serial_adder_ctrl #(.NBYTES(4)) u4 (.i_clk(clk), .i_rst(rst), .i_start(s4), .i_op(op4),
    .i_a(a4), .i_b(b4), .o_ready(rdy4), .o_busy(bsy4), .o_done(dn4), .o_result(res4), .o_cout(co4));

  int checks = 0, errors = 0, viol = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input int n, input logic st, input logic [63:0] a, input logic [63:0] b, input logic op);
    case (n)
      2: begin s2 = st; a2 = a[15:0]; b2 = b[15:0]; op2 = op; end
      3: begin s3 = st; a3 = a[23:0]; b3 = b[23:0]; op3 = op; end
      default: begin s4 = st; a4 = a[31:0]; b4 = b[31:0]; op4 = op; end
    endcase
  endtask

  function automatic logic [3:0] flags(input int n); // {ready,busy,done,cout}
    case (n)
      2: return {rdy2, bsy2, dn2, co2};
      3: return {rdy3, bsy3, dn3, co3};
      default: return {rdy4, bsy4, dn4, co4};
    endcase
  endfunction

  function automatic logic [63:0] result(input int n);
    case (n)
      2: return {48'd0, res2};
      3: return {40'd0, res3};
      default: return {32'd0, res4};
    endcase
  endfunction

  // Launch one op and wait for done; lat counts edges from the start edge to done.
  task automatic run_op(input int n, input logic [63:0] a, input logic [63:0] b, input logic op,
                        output logic [63:0] res, output logic co, output int lat, output int nbusy);
    logic [3:0] f;
    @(negedge clk); drive(n, 1'b1, a, b, op);
    @(negedge clk); drive(n, 1'b0, ~a, ~b, ~op);
    lat = 0; nbusy = 0;
    f = flags(n);
    while (!f[1] && lat < 20) begin
      if (f[2]) nbusy++;
      if (f[3] && f[2]) viol++;
      @(negedge clk); lat++;
      f = flags(n);
    end
    if (!f[3]) viol++;
    if (lat >= 20) check("done_timeout", 64'(lat), 64'(n));
    res = result(n); co = f[0];
  endtask

  typedef struct {
    logic [23:0] a, b; logic op; logic [23:0] res; logic co;
  } vec_t;
  vec_t tbl[6];

  function automatic void model(input int n, input logic [63:0] a, input logic [63:0] b, input logic op,
                                output logic [63:0] res, output logic co);
    longint unsigned m, aa, bb, s;
    m  = (64'd1 << (8*n)) - 1;
    aa = a & m; bb = b & m;
    if (op) begin res = (aa - bb) & m; co = (aa >= bb); end
    else begin s = aa + bb; res = s & m; co = s[8*n]; end
  endfunction

  initial begin
    logic [63:0] r, er, ra, rb; logic c, ec, rop; int lat, nb, nd, k1, k2;
    logic [63:0] r1, r2;
    tbl[0] = '{24'h123456, 24'h0000AA, 1'b0, 24'h123500, 1'b0};
    tbl[1] = '{24'hFFFFFF, 24'h000001, 1'b0, 24'h000000, 1'b1};
    tbl[2] = '{24'h100000, 24'h000001, 1'b1, 24'h0FFFFF, 1'b1};
    tbl[3] = '{24'h000001, 24'h000002, 1'b1, 24'hFFFFFF, 1'b0};
    tbl[4] = '{24'h00FF00, 24'h00FF00, 1'b1, 24'h000000, 1'b1};
    tbl[5] = '{24'h800000, 24'h800000, 1'b0, 24'h000000, 1'b1};

    repeat (2) @(negedge clk);
    check("rst_flags", 64'(flags(3)), 64'b1000);
    check("rst_result", result(3), 64'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_op(3, 64'(tbl[i].a), 64'(tbl[i].b), tbl[i].op, r, c, lat, nb);
      check($sformatf("tbl%0d_result", i), r, 64'(tbl[i].res));
      check($sformatf("tbl%0d_cout", i), 64'(c), 64'(tbl[i].co));
      check($sformatf("tbl%0d_latency", i), 64'(lat), 64'd3);
      check($sformatf("tbl%0d_busy_cycles", i), 64'(nb), 64'd3);
      @(negedge clk);
      check($sformatf("tbl%0d_done_pulse", i), 64'(flags(3)), {60'd0, 3'b100, tbl[i].co});
    end

    // start while busy is ignored
    @(negedge clk); drive(3, 1, 64'h10, 64'h20, 0);
    @(negedge clk); drive(3, 0, 64'h10, 64'h20, 0);
    @(negedge clk); drive(3, 1, 64'hFFFFFF, 64'h20, 0);
    @(negedge clk); drive(3, 0, 64'hFFFFFF, 64'h20, 0);
    nd = 0; r = '0;
    for (int k = 0; k < 10; k++) begin
      if (dn3) begin nd++; r = result(3); end
      @(negedge clk);
    end
    check("busy_start_dones", 64'(nd), 64'd1);
    check("busy_start_result", r, 64'h30);

    // reset mid-op
    @(negedge clk); drive(3, 1, 64'h0000F1, 64'h000002, 0);
    @(negedge clk); drive(3, 0, 64'h0, 64'h0, 0);
    @(negedge clk);
    rst = 1'b1; #1;
    check("midrst_flags", 64'(flags(3)), 64'b1000);
    check("midrst_result", result(3), 64'd0);
    @(negedge clk); rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      if (dn3) nd++;
      @(negedge clk);
    end
    check("midrst_no_done", 64'(nd), 64'd0);
    run_op(3, 64'h0000F1, 64'h000002, 0, r, c, lat, nb);
    check("midrst_after_result", r, 64'h0000F3);

    // back-to-back with start held high
    @(negedge clk); drive(3, 1, 64'h1, 64'h1, 0);
    @(negedge clk); drive(3, 1, 64'hFF, 64'h1, 0);
    nd = 0; k1 = -1; k2 = -1; r1 = '0; r2 = '0;
    for (int k = 0; k < 12; k++) begin
      if (dn3) begin
        nd++;
        if (nd == 1) begin k1 = k; r1 = result(3); end
        else begin k2 = k; r2 = result(3); end
      end
      if (k == 4) drive(3, 0, 64'h0, 64'h0, 0);
      @(negedge clk);
    end
    check("b2b_dones", 64'(nd), 64'd2);
    check("b2b_first_at", 64'(k1), 64'd3);
    check("b2b_first_result", r1, 64'h2);
    check("b2b_second_at", 64'(k2), 64'd7);
    check("b2b_second_result", r2, 64'h100);

    // random sweeps
    for (int n = 2; n <= 4; n += 2) begin
      for (int i = 0; i < 1000; i++) begin
        ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rop = 1'($urandom);
        if (i % 10 == 0) rb = ra;
        if (i % 10 == 1) rb = (rb & 64'hFF) | (64'hFF << 8);
        model(n, ra, rb, rop, er, ec);
        run_op(n, ra, rb, rop, r, c, lat, nb);
        check($sformatf("rnd_n%0d_%0d_result", n, i), r, er);
        check($sformatf("rnd_n%0d_%0d_cout", n, i), 64'(c), 64'(ec));
        if (lat != n) check($sformatf("rnd_n%0d_%0d_latency", n, i), 64'(lat), 64'(n));
      end
    end

    check("ready_busy_done_exclusivity", 64'(viol), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
